char_display_scanner: RTL

CHAR_DISPLAY_SCANNER -- requirements
Module: char_display_scanner

---
 rtl/char_display_scanner.sv | 137 +++++++++++++
 1 files changed

// File: rtl/char_display_scanner.sv
// Text-mode VGA scanner: walks the raster, reads glyph codes and font rows,
// and drives registered syncs, videoOn and RGB332 pixels two pixel periods behind the counters.
module char_display_scanner #(
   parameter int         H_VISIBLE = 640,
   parameter int         H_FRONT   = 16,
   parameter int         H_SYNC    = 96,
   parameter int         H_BACK    = 48,
   parameter int         V_VISIBLE = 480,
   parameter int         V_FRONT   = 10,
   parameter int         V_SYNC    = 2,
   parameter int         V_BACK    = 33,
   parameter logic [7:0] FG_COLOR  = 8'hFF,
   parameter logic [7:0] BG_COLOR  = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   output logic [7:0] hGlyphVGA,
   output logic [6:0] vGlyphVGA,
   input  logic [6:0] glyphCode,
   output logic [9:0] fontAddr,
   input  logic [7:0] fontRow,
   output logic       hSync,
   output logic       vSync,
   output logic       videoOn,
   output logic [7:0] rgb
);

   localparam logic [9:0] H_LAST       = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [9:0] V_LAST       = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [9:0] H_VIS        = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
   localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

   logic       strobe_q, strobe_d;
   logic [9:0] h_count_q, h_count_d;
   logic [9:0] v_count_q, v_count_d;
   logic [6:0] s1_code_q, s1_code_d;
   logic [2:0] s1_hpix_q, s1_hpix_d;
   logic [2:0] s1_vpix_q, s1_vpix_d;
   logic       s1_hsync_q, s1_hsync_d;
   logic       s1_vsync_q, s1_vsync_d;
   logic       s1_vis_q, s1_vis_d;
   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;
   logic       video_on_q, video_on_d;
   logic [7:0] rgb_q, rgb_d;

   logic       hsync_raw, vsync_raw, vis_raw, pixel_bit;

   always_comb begin
      strobe_d   = ~strobe_q;
      h_count_d  = h_count_q;
      v_count_d  = v_count_q;
      s1_code_d  = s1_code_q;
      s1_hpix_d  = s1_hpix_q;
      s1_vpix_d  = s1_vpix_q;
      s1_hsync_d = s1_hsync_q;
      s1_vsync_d = s1_vsync_q;
      s1_vis_d   = s1_vis_q;
      hsync_d    = hsync_q;
      vsync_d    = vsync_q;
      video_on_d = video_on_q;
      rgb_d      = rgb_q;

      hsync_raw = !((h_count_q >= H_SYNC_START) && (h_count_q < H_SYNC_END));
      vsync_raw = !((v_count_q >= V_SYNC_START) && (v_count_q < V_SYNC_END));
      vis_raw   = (h_count_q < H_VIS) && (v_count_q < V_VIS);
      pixel_bit = fontRow[3'd7 - s1_hpix_q];

      if (strobe_q) begin
         if (h_count_q == H_LAST) begin
            h_count_d = 10'd0;
            v_count_d = (v_count_q == V_LAST) ? 10'd0 : v_count_q + 10'd1;
         end else begin
            h_count_d = h_count_q + 10'd1;
         end

         s1_code_d  = glyphCode;
         s1_hpix_d  = h_count_q[2:0];
         s1_vpix_d  = v_count_q[2:0];
         s1_hsync_d = hsync_raw;
         s1_vsync_d = vsync_raw;
         s1_vis_d   = vis_raw;

         // fontRow here answers fontAddr built from the stage-1 registers.
         hsync_d    = s1_hsync_q;
         vsync_d    = s1_vsync_q;
         video_on_d = s1_vis_q;
         rgb_d      = s1_vis_q ? (pixel_bit ? FG_COLOR : BG_COLOR) : 8'h00;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         strobe_q   <= 1'b0;
         h_count_q  <= 10'd0;
         v_count_q  <= 10'd0;
         s1_code_q  <= 7'd0;
         s1_hpix_q  <= 3'd0;
         s1_vpix_q  <= 3'd0;
         // Stage-1 syncs idle high so the first stage-2 load cannot glitch the pins low.
         s1_hsync_q <= 1'b1;
         s1_vsync_q <= 1'b1;
         s1_vis_q   <= 1'b0;
         hsync_q    <= 1'b1;
         vsync_q    <= 1'b1;
         video_on_q <= 1'b0;
         rgb_q      <= 8'h00;
      end else begin
         strobe_q   <= strobe_d;
         h_count_q  <= h_count_d;
         v_count_q  <= v_count_d;
         s1_code_q  <= s1_code_d;
         s1_hpix_q  <= s1_hpix_d;
         s1_vpix_q  <= s1_vpix_d;
         s1_hsync_q <= s1_hsync_d;
         s1_vsync_q <= s1_vsync_d;
         s1_vis_q   <= s1_vis_d;
         hsync_q    <= hsync_d;
         vsync_q    <= vsync_d;
         video_on_q <= video_on_d;
         rgb_q      <= rgb_d;
      end
   end

   assign hGlyphVGA = {1'b0, h_count_q[9:3]};
   assign vGlyphVGA = {1'b0, v_count_q[8:3]};
   assign fontAddr  = {s1_code_q, s1_vpix_q};
   assign hSync     = hsync_q;
   assign vSync     = vsync_q;
   assign videoOn   = video_on_q;
   assign rgb       = rgb_q;

endmodule
